// File: rtl/mem_copy_dma_if.sv
// rtl/mem_copy_dma_if.sv - bus and control bundle between mem_copy_dma and its memory/arbiter side
interface mem_copy_dma_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
);
  logic              i_start;
  logic [ADDR_W-1:0] i_src;
  logic [ADDR_W-1:0] i_dst;
  logic [LEN_W-1:0]  i_len;
  logic              i_grant;
  logic              o_rd;
  logic              o_wr;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_bus;
  logic [DATA_W-1:0] i_bus;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_start, i_src, i_dst, i_len, i_grant, i_bus,
    output o_rd, o_wr, o_address, o_bus, o_busy, o_done
  );

  modport slave (
    output i_start, i_src, i_dst, i_len, i_grant, i_bus,
    input  o_rd, o_wr, o_address, o_bus, o_busy, o_done
  );
endinterface

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - second bus master copying a block of words, one read/wait/write per word
module mem_copy_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mem_copy_dma_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int CNT_W = 3;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              rd, wr, done;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rd      = 1'b0;
    wr      = 1'b0;
    done    = 1'b0;
    addr    = '0;
    wdata   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          src_d   = bus.i_src;
          dst_d   = bus.i_dst;
          rem_d   = bus.i_len;
          state_d = (bus.i_len == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        if (bus.i_grant) begin
          rd      = 1'b1;
          addr    = src_q;
          cnt_d   = CNT_W'(RD_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Grant is not consulted: the read is already in flight at the memory.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          data_d  = bus.i_bus;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (bus.i_grant) begin
          wr      = 1'b1;
          addr    = dst_q;
          wdata   = data_q;
          src_d   = src_q + ADDR_W'(1);
          dst_d   = dst_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_rd      = rd;
  assign bus.o_wr      = wr;
  assign bus.o_address = addr;
  assign bus.o_bus     = wdata;
  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_done    = done;
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - scoreboard bench for mem_copy_dma with RD_LAT=1 and RD_LAT=3 instances
module tb_mem_copy_dma;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_copy_dma_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) if1 ();
  mem_copy_dma_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) if3 ();

  mem_copy_dma #(.ADDR_W(16), .DATA_W(16), .LEN_W(16), .RD_LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(if1));
  mem_copy_dma #(.ADDR_W(16), .DATA_W(16), .LEN_W(16), .RD_LAT(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .bus(if3));

  logic        start1, start3, grant, sel, chk_lat;
  logic [15:0] src, dst, len;
  logic [15:0] mem [0:65535];
  logic [15:0] pipe [0:2];

  assign if1.i_start = start1;
  assign if3.i_start = start3;
  assign if1.i_src = src;
  assign if3.i_src = src;
  assign if1.i_dst = dst;
  assign if3.i_dst = dst;
  assign if1.i_len = len;
  assign if3.i_len = len;
  assign if1.i_grant = grant;
  assign if3.i_grant = grant;
  assign if1.i_bus = pipe[0];
  assign if3.i_bus = pipe[2];

  logic        m_rd, m_wr, m_busy, m_done;
  logic [15:0] m_addr, m_wdata;
  assign m_rd    = sel ? if3.o_rd      : if1.o_rd;
  assign m_wr    = sel ? if3.o_wr      : if1.o_wr;
  assign m_busy  = sel ? if3.o_busy    : if1.o_busy;
  assign m_done  = sel ? if3.o_done    : if1.o_done;
  assign m_addr  = sel ? if3.o_address : if1.o_address;
  assign m_wdata = sel ? if3.o_bus     : if1.o_bus;

  // Memory: read data emerges RD_LAT edges after the o_rd cycle; other cycles carry junk.
  always @(posedge clk) begin
    pipe[0] <= m_rd ? mem[m_addr] : 16'hDEAD;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    if (m_wr) mem[m_addr] <= m_wdata;
  end

  int n_cmp = 0, n_fail = 0;
  logic [15:0] exp_rd [$];
  logic [31:0] exp_wr [$];

  task automatic check(string name, logic [47:0] act, logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int cyc = 0, rd_cyc = 0, rd_total = 0, wr_total = 0, done_total = 0;
  int busy_run = 0, last_busy = 0;
  logic [15:0] e_rd;
  logic [31:0] e_wr;

  always @(negedge clk) begin
    if ((m_rd || m_wr) && !grant) check("strobe_without_grant", 1, 0);
    if (m_rd && m_wr) check("rd_wr_overlap", 1, 0);
    if (m_rd) begin
      rd_total++;
      rd_cyc = cyc;
      if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e_rd = exp_rd.pop_front();
        check("rd_addr", m_addr, e_rd);
      end
    end
    if (m_wr) begin
      wr_total++;
      if (chk_lat) check("rd_to_wr_gap", cyc - rd_cyc, 4);
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e_wr = exp_wr.pop_front();
        check("wr_addr_data", {m_addr, m_wdata}, e_wr);
      end
    end
    if (m_done) done_total++;
    if (m_busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run = 0;
    end
    cyc++;
  end

  int b_rd, b_wr, b_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: word i reads src+i and writes the source word to dst+i, modulo 2^16.
  task automatic start_copy(logic [15:0] s, logic [15:0] d, logic [15:0] l, int nrd, int nwr);
    for (int i = 0; i < nrd; i++) exp_rd.push_back(16'(s + 16'(i)));
    for (int i = 0; i < nwr; i++) exp_wr.push_back({16'(d + 16'(i)), mem[16'(s + 16'(i))]});
    b_rd = rd_total;
    b_wr = wr_total;
    b_done = done_total;
    src = s;
    dst = d;
    len = l;
    if (sel) start3 = 1'b1;
    else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic run_until_idle(bit rnd_grant);
    int n = 0;
    while (m_busy && n < 600) begin
      if (rnd_grant) grant = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    grant = 1'b1;
    if (n >= 600) check("idle_timeout", 1, 0);
    tick();
  endtask

  task automatic tally(string tag, int nrd, int nwr, int ndone, int busy);
    check({tag, "_rd_count"}, rd_total - b_rd, nrd);
    check({tag, "_wr_count"}, wr_total - b_wr, nwr);
    check({tag, "_done_count"}, done_total - b_done, ndone);
    if (busy >= 0) check({tag, "_busy_cycles"}, last_busy, busy);
    check({tag, "_rd_queue_left"}, exp_rd.size(), 0);
    check({tag, "_wr_queue_left"}, exp_wr.size(), 0);
  endtask

  task automatic mem_match(string tag, logic [15:0] s, logic [15:0] d, int l);
    for (int i = 0; i < l; i++)
      check({tag, "_dst_word"}, mem[16'(d + 16'(i))], mem[16'(s + 16'(i))]);
  endtask

  logic [15:0] old_w [3];
  logic [15:0] rs, rdst, rl;

  initial begin
    rst = 1'b1; grant = 1'b1; start1 = 1'b0; start3 = 1'b0;
    src = '0; dst = '0; len = '0; sel = 1'b0; chk_lat = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] <= 16'($urandom);
    mem[16'h0100] <= 16'h1111;
    mem[16'h0101] <= 16'h2222;
    mem[16'h0102] <= 16'h3333;
    mem[16'h0103] <= 16'h4444;
    tick();
    tick();
    check("reset_outputs_lat1", {if1.o_rd, if1.o_wr, if1.o_busy, if1.o_done, if1.o_address, if1.o_bus}, 0);
    check("reset_outputs_lat3", {if3.o_rd, if3.o_wr, if3.o_busy, if3.o_done, if3.o_address, if3.o_bus}, 0);
    rst = 1'b0;
    tick();

    start_copy(16'h0100, 16'h0200, 16'd4, 4, 4);
    run_until_idle(1'b0);
    tally("basic", 4, 4, 1, 13);
    check("basic_word0", mem[16'h0200], 16'h1111);
    check("basic_word1", mem[16'h0201], 16'h2222);
    check("basic_word2", mem[16'h0202], 16'h3333);
    check("basic_word3", mem[16'h0203], 16'h4444);

    start_copy(16'h0100, 16'h0250, 16'd0, 0, 0);
    run_until_idle(1'b0);
    tally("len0", 0, 0, 1, 1);

    start_copy(16'h0100, 16'h0300, 16'd4, 4, 4);
    for (int c = 1; c <= 21; c++) begin
      grant = !((c >= 4 && c <= 8) || (c >= 14 && c <= 16));
      tick();
    end
    grant = 1'b1;
    run_until_idle(1'b0);
    tally("stall", 4, 4, 1, 21);
    mem_match("stall", 16'h0100, 16'h0300, 4);

    start_copy(16'hFFFE, 16'h0010, 16'd3, 3, 3);
    run_until_idle(1'b0);
    tally("wrap", 3, 3, 1, 10);
    mem_match("wrap", 16'hFFFE, 16'h0010, 3);

    for (int i = 0; i < 3; i++) old_w[i] = mem[16'h0501 + 16'(i)];
    start_copy(16'h0400, 16'h0500, 16'd4, 2, 1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outputs", {if1.o_rd, if1.o_wr, if1.o_busy, if1.o_done, if1.o_address, if1.o_bus}, 0);
    tick();
    tick();
    tally("rst_mid", 2, 1, 0, -1);
    check("rst_mid_dst0", mem[16'h0500], mem[16'h0400]);
    for (int i = 0; i < 3; i++) check("rst_mid_untouched", mem[16'h0501 + 16'(i)], old_w[i]);
    start_copy(16'h0600, 16'h0700, 16'd1, 1, 1);
    run_until_idle(1'b0);
    tally("after_rst", 1, 1, 1, 4);
    mem_match("after_rst", 16'h0600, 16'h0700, 1);

    sel = 1'b1;
    chk_lat = 1'b1;
    tick();
    start_copy(16'h0800, 16'h0900, 16'd2, 2, 2);
    tick();
    src = 16'h1234; dst = 16'h4321; len = 16'd5; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    run_until_idle(1'b0);
    tally("lat3", 2, 2, 1, 11);
    mem_match("lat3", 16'h0800, 16'h0900, 2);
    chk_lat = 1'b0;

    for (int k = 0; k < 8; k++) begin
      sel = 1'($urandom_range(0, 1));
      tick();
      rs = 16'h2000 + 16'($urandom_range(0, 16'h0FFF));
      rdst = 16'hA000 + 16'($urandom_range(0, 16'h0FFF));
      rl = 16'($urandom_range(1, 8));
      start_copy(rs, rdst, rl, int'(rl), int'(rl));
      run_until_idle(1'b1);
      tally("random", int'(rl), int'(rl), 1, -1);
      mem_match("random", rs, rdst, int'(rl));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
